// File: rtl/corn_frame_sequencer.sv
// Buffers one frame from a word stream, replays it to a CORNDesign core and returns the core result; optional watchdog under CORN_SEQ_TIMEOUT_EN.
// Latency: InputReady pulses 1 cycle after the last word is accepted, words follow on the next 16 cycles, result valid 1 cycle after Done.
// Backpressure: InReady only in FILL; the result is held on OutValid/OutReady and no new frame is taken until Done drops.
module corn_frame_sequencer #(
   parameter int FRAME_LEN      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         InValid,
   input  logic [15:0]  InData,
   output logic         InReady,
   output logic         CoreEn,
   output logic         CoreInputReady,
   output logic [15:0]  CoreInputs,
   input  logic         CoreDone,
   input  logic [127:0] CoreQ,
   output logic         OutValid,
   output logic [127:0] OutData,
   input  logic         OutReady,
   output logic         Busy,
   output logic         Error
);

   localparam int CW = $clog2(FRAME_LEN);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_START, S_STREAM, S_WAIT, S_RESULT, S_REARM
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [15:0]     frame_buf [FRAME_LEN];
   logic            wr_en;
   logic            in_ready_nxt;
   logic            core_ir_nxt;
   logic [15:0]     core_inputs_nxt;
   logic            out_valid_nxt;
   logic [127:0]    out_data_nxt;
   logic            busy_nxt;

`ifdef CORN_SEQ_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo, tmo_nxt;
   logic        err_nxt;
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYCLES;
   assign Error      = 1'b0;
`endif

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      wr_en           = 1'b0;
      in_ready_nxt    = 1'b0;
      core_ir_nxt     = 1'b0;
      core_inputs_nxt = '0;
      out_valid_nxt   = OutValid;
      out_data_nxt    = OutData;
`ifdef CORN_SEQ_TIMEOUT_EN
      tmo_nxt         = tmo;
      err_nxt         = Error;
`endif
      case (state)
         S_IDLE: begin
            state_nxt    = S_FILL;
            in_ready_nxt = 1'b1;
         end
         S_FILL: begin
            in_ready_nxt = 1'b1;
            if (InValid && InReady) begin
               wr_en = 1'b1;
               if (cnt == LAST) begin
                  cnt_nxt      = '0;
                  in_ready_nxt = 1'b0;
                  core_ir_nxt  = 1'b1;
                  state_nxt    = S_START;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         S_START: begin
            core_inputs_nxt = frame_buf[0];
            cnt_nxt         = CW'(1);
            state_nxt       = S_STREAM;
         end
         S_STREAM: begin
            // cnt wraps back to 0 once the last word has been issued
            if (cnt == '0) begin
               state_nxt = S_WAIT;
`ifdef CORN_SEQ_TIMEOUT_EN
               tmo_nxt   = '0;
`endif
            end else begin
               core_inputs_nxt = frame_buf[cnt];
               cnt_nxt         = (cnt == LAST) ? '0 : cnt + 1'b1;
            end
         end
         S_WAIT: begin
            if (CoreDone) begin
               out_data_nxt  = CoreQ;
               out_valid_nxt = 1'b1;
               state_nxt     = S_RESULT;
            end
`ifdef CORN_SEQ_TIMEOUT_EN
            else if (tmo == TMO_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = S_REARM;
            end else begin
               tmo_nxt = tmo + 16'd1;
            end
`endif
         end
         S_RESULT: begin
            if (OutValid && OutReady) begin
               out_valid_nxt = 1'b0;
               state_nxt     = S_REARM;
            end
         end
         S_REARM: begin
            // a Done still high from the previous frame must not complete the next one
            if (!CoreDone) begin
               state_nxt    = S_FILL;
               in_ready_nxt = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      busy_nxt = !(state_nxt inside {S_IDLE, S_FILL});
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state          <= S_IDLE;
         cnt            <= '0;
         InReady        <= 1'b0;
         CoreEn         <= 1'b0;
         CoreInputReady <= 1'b0;
         CoreInputs     <= '0;
         OutValid       <= 1'b0;
         OutData        <= '0;
         Busy           <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         InReady        <= in_ready_nxt;
         CoreEn         <= 1'b1;
         CoreInputReady <= core_ir_nxt;
         CoreInputs     <= core_inputs_nxt;
         OutValid       <= out_valid_nxt;
         OutData        <= out_data_nxt;
         Busy           <= busy_nxt;
      end
   end

`ifdef CORN_SEQ_TIMEOUT_EN
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         tmo   <= '0;
         Error <= 1'b0;
      end else begin
         tmo   <= tmo_nxt;
         Error <= err_nxt;
      end
   end
`endif

   always_ff @(posedge Clk) begin
      if (wr_en) frame_buf[cnt] <= InData;
   end

endmodule

// File: tb/tb_corn_frame_sequencer.sv
// Scoreboarded bench for corn_frame_sequencer: accepted words are queued and compared as they appear on CoreInputs.
module tb_corn_frame_sequencer;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         InValid;
   logic [15:0]  InData;
   logic         InReady;
   logic         CoreEn;
   logic         CoreInputReady;
   logic [15:0]  CoreInputs;
   logic         CoreDone;
   logic [127:0] CoreQ;
   logic         OutValid;
   logic [127:0] OutData;
   logic         OutReady;
   logic         Busy;
   logic         Error;

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_q [$];

   logic [15:0]  frame_a [16];
   logic [15:0]  frame_b [16];
   logic [127:0] q_a;
   logic [127:0] q_b;

   always #5 Clk = ~Clk;

   corn_frame_sequencer #(.FRAME_LEN(16), .TIMEOUT_CYCLES(20)) dut (
      .Clk(Clk), .Rst(Rst), .InValid(InValid), .InData(InData), .InReady(InReady),
      .CoreEn(CoreEn), .CoreInputReady(CoreInputReady), .CoreInputs(CoreInputs),
      .CoreDone(CoreDone), .CoreQ(CoreQ), .OutValid(OutValid), .OutData(OutData),
      .OutReady(OutReady), .Busy(Busy), .Error(Error)
   );

   // Drives one frame; pushes each accepted word to the scoreboard. Called on a falling edge.
   task automatic send_frame(input logic [15:0] w [16], input bit gappy, output int cyc, output bit early);
      int i;
      int n;
      bit tog;
      logic rdy;
      i = 0; n = 0; tog = 1'b1; cyc = 0; early = 1'b0;
      while (i < 16 && n < 400) begin
         InValid = gappy ? tog : 1'b1;
         InData  = InValid ? w[i] : 16'($urandom);
         rdy     = InReady;
         @(negedge Clk);
         n++; cyc++;
         if (InValid && rdy) begin
            exp_q.push_back(w[i]);
            i++;
         end
         if (CoreInputReady && i < 16) early = 1'b1;
         tog = ~tog;
      end
      InValid = 1'b0;
      InData  = 16'h0;
      checks++; if (i != 16) begin failures++; $display("FAIL send_frame accepted=%0d required=16", i); end
   endtask

   task automatic test_reset();
      int cyc;
      bit early;
      Rst = 1'b1; InValid = 1'b0; InData = 16'h0; CoreDone = 1'b0; CoreQ = '0; OutReady = 1'b0;
      repeat (2) @(negedge Clk);
      checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL rst_inready got=%b exp=0", InReady); end
      checks++; if (CoreEn !== 1'b0) begin failures++; $display("FAIL rst_coreen got=%b exp=0", CoreEn); end
      checks++; if (CoreInputReady !== 1'b0) begin failures++; $display("FAIL rst_coreir got=%b exp=0", CoreInputReady); end
      checks++; if (CoreInputs !== 16'h0) begin failures++; $display("FAIL rst_coreinputs got=%h exp=0", CoreInputs); end
      checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL rst_outvalid got=%b exp=0", OutValid); end
      checks++; if (OutData !== 128'h0) begin failures++; $display("FAIL rst_outdata got=%h exp=0", OutData); end
      checks++; if (Busy !== 1'b0 || Error !== 1'b0) begin failures++; $display("FAIL rst_busy_err got=%b%b exp=00", Busy, Error); end
      Rst = 1'b0;
      @(negedge Clk);
      checks++; if (CoreEn !== 1'b1) begin failures++; $display("FAIL idle_coreen got=%b exp=1", CoreEn); end
      checks++; if (InReady !== 1'b1 || Busy !== 1'b0) begin failures++; $display("FAIL fill_entry rdy/busy got=%b%b exp=10", InReady, Busy); end
      // partial frame of 5 words, then abort
      InValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         InData = 16'hBEE0 + 16'(i);
         @(negedge Clk);
      end
      InValid = 1'b0;
      Rst = 1'b1;
      #1;
      checks++; if (InReady !== 1'b0 || CoreEn !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL midrst_outs got=%b%b%b exp=000", InReady, CoreEn, Busy); end
      checks++; if (CoreInputs !== 16'h0 || OutData !== 128'h0 || OutValid !== 1'b0) begin failures++; $display("FAIL midrst_data got=%h/%h exp=0", CoreInputs, OutData); end
      @(negedge Clk);
      Rst = 1'b0;
      exp_q.delete();
      @(negedge Clk);
      checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL refill_ready got=%b exp=1", InReady); end
      send_frame(frame_a, 1'b0, cyc, early);
      checks++; if (early !== 1'b0) begin failures++; $display("FAIL early_start got=%b exp=0", early); end
      checks++; if (cyc !== 16) begin failures++; $display("FAIL b2b_cycles got=%0d exp=16", cyc); end
   endtask

   // Entered on the cycle after the last word was accepted.
   task automatic test_stream(input string tag);
      logic [15:0] exp;
      checks++; if (CoreInputReady !== 1'b1) begin failures++; $display("FAIL %s_ir_pulse got=%b exp=1", tag, CoreInputReady); end
      checks++; if (CoreInputs !== 16'h0 || InReady !== 1'b0 || Busy !== 1'b1) begin failures++; $display("FAIL %s_start got=%h/%b/%b exp=0000/0/1", tag, CoreInputs, InReady, Busy); end
      for (int i = 0; i < 16; i++) begin
         @(negedge Clk);
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
         checks++; if (CoreInputs !== exp || CoreInputReady !== 1'b0) begin failures++; $display("FAIL %s_word%0d got=%h ir=%b exp=%h ir=0", tag, i, CoreInputs, CoreInputReady, exp); end
      end
      @(negedge Clk);
      checks++; if (CoreInputs !== 16'h0 || OutValid !== 1'b0) begin failures++; $display("FAIL %s_wait_entry got=%h/%b exp=0000/0", tag, CoreInputs, OutValid); end
   endtask

   task automatic test_result();
      repeat (3) begin
         @(negedge Clk);
         checks++; if (OutValid !== 1'b0 || Busy !== 1'b1) begin failures++; $display("FAIL wait_idle got=%b/%b exp=0/1", OutValid, Busy); end
      end
      CoreQ = q_a; CoreDone = 1'b1;
      @(negedge Clk);
      CoreQ = ~q_a;
      checks++; if (OutValid !== 1'b1 || Busy !== 1'b1) begin failures++; $display("FAIL result_valid got=%b/%b exp=1/1", OutValid, Busy); end
      checks++; if (OutData !== q_a) begin failures++; $display("FAIL result_data got=%h exp=%h", OutData, q_a); end
      repeat (10) begin
         @(negedge Clk);
         checks++; if (OutData !== q_a || OutValid !== 1'b1 || InReady !== 1'b0) begin failures++; $display("FAIL hold got=%h/%b/%b exp=%h/1/0", OutData, OutValid, InReady, q_a); end
      end
      OutReady = 1'b1;
      @(negedge Clk);
      OutReady = 1'b0;
      checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL handshake_drop got=%b exp=0", OutValid); end
      repeat (2) begin
         @(negedge Clk);
         checks++; if (InReady !== 1'b0 || OutValid !== 1'b0 || Busy !== 1'b1) begin failures++; $display("FAIL rearm_hold got=%b/%b/%b exp=0/0/1", InReady, OutValid, Busy); end
      end
      CoreDone = 1'b0;
      @(negedge Clk);
      checks++; if (InReady !== 1'b1 || Busy !== 1'b0) begin failures++; $display("FAIL rearm_exit got=%b/%b exp=1/0", InReady, Busy); end
   endtask

   // Gapped upstream with CoreDone held high throughout; Done is ignored until WAIT and then completes at once.
   task automatic test_gappy();
      int cyc;
      bit early;
      CoreDone = 1'b1; CoreQ = q_b;
      send_frame(frame_b, 1'b1, cyc, early);
      checks++; if (cyc !== 31) begin failures++; $display("FAIL gappy_cycles got=%0d exp=31", cyc); end
      checks++; if (early !== 1'b0) begin failures++; $display("FAIL gappy_early got=%b exp=0", early); end
      test_stream("gappy");
      @(negedge Clk);
      checks++; if (OutValid !== 1'b1 || OutData !== q_b) begin failures++; $display("FAIL early_done got=%b/%h exp=1/%h", OutValid, OutData, q_b); end
      CoreDone = 1'b0; OutReady = 1'b1;
      @(negedge Clk);
      OutReady = 1'b0;
      checks++; if (OutValid !== 1'b0 || InReady !== 1'b0) begin failures++; $display("FAIL fast_rearm got=%b/%b exp=0/0", OutValid, InReady); end
      @(negedge Clk);
      checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL fast_fill got=%b exp=1", InReady); end
   endtask

   task automatic test_timeout();
      int cyc;
      bit early;
      send_frame(frame_a, 1'b0, cyc, early);
      test_stream("tmo");
`ifdef CORN_SEQ_TIMEOUT_EN
      repeat (19) begin
         @(negedge Clk);
         checks++; if (Error !== 1'b0 || OutValid !== 1'b0) begin failures++; $display("FAIL tmo_pre got=%b/%b exp=0/0", Error, OutValid); end
      end
      @(negedge Clk);
      checks++; if (Error !== 1'b1 || OutValid !== 1'b0) begin failures++; $display("FAIL tmo_fire got=%b/%b exp=1/0", Error, OutValid); end
      @(negedge Clk);
      checks++; if (InReady !== 1'b1 || Error !== 1'b1 || OutData !== q_b) begin failures++; $display("FAIL tmo_refill got=%b/%b/%h exp=1/1/%h", InReady, Error, OutData, q_b); end
`else
      repeat (40) @(negedge Clk);
      checks++; if (Error !== 1'b0 || OutValid !== 1'b0 || Busy !== 1'b1 || InReady !== 1'b0) begin failures++; $display("FAIL no_tmo got=%b/%b/%b/%b exp=0/0/1/0", Error, OutValid, Busy, InReady); end
`endif
      checks++; if (CoreEn !== 1'b1) begin failures++; $display("FAIL coreen_hold got=%b exp=1", CoreEn); end
   endtask

   initial begin
      frame_a = '{16'h00A8, 16'h00D7, 16'h0091, 16'h0025, 16'h00E7, 16'h0067, 16'h0055, 16'h0025,
                  16'h0050, 16'h00E6, 16'h00B2, 16'h00A6, 16'h0040, 16'h00C3, 16'h0016, 16'h005E};
      for (int i = 0; i < 16; i++) frame_b[i] = 16'($urandom);
      q_a = {16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
      q_b = {$urandom, $urandom, $urandom, $urandom};
      test_reset();
      test_stream("frame_a");
      test_result();
      test_gappy();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
